// File: rtl/eth_pkg.sv
// Shared Ethernet definitions for the GMII transmit framer and the receive-side FCS checker.
package eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG,
    ST_DROP
  } tx_state_e;

  localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
  localparam logic [7:0]  ETH_SFD      = 8'hD5;
  localparam logic [31:0] CRC32_POLY   = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;

  // FCS is the inverted CRC register, transmitted least significant byte first.
  function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] idx);
    logic [31:0] fcs;
    fcs = ~crc;
    return fcs[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational next-state of the reflected IEEE 802.3 CRC-32, one byte per call.
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] c;

  always_comb begin
    c = crc_i;
    for (int i = 0; i < 8; i++) begin
      c = (c >> 1) ^ (((c[0] ^ data_i[i]) == 1'b1) ? CRC32_POLY : 32'h0);
    end
    crc_o = c;
  end

endmodule

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD insertion, short-frame padding, CRC-32 FCS and IFG.
module gmii_tx_framer
  import eth_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_FRAME    = 60,
  parameter int IFG_CYCLES   = 12
) (
  input  logic        gmii_tx_clk,
  input  logic        sys_rst_n,
  input  logic        tx_link_up,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic        tx_busy,
  output logic        underrun,
  output logic [15:0] frame_cnt
);

  localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_CYCLES);
  localparam logic [10:0] MIN_LEN  = 11'(MIN_FRAME);

  tx_state_e   state_q, state_d;
  logic [10:0] byte_cnt_q, byte_cnt_d, byte_inc;
  logic [7:0]  aux_cnt_q, aux_cnt_d;
  logic [31:0] crc_q, crc_d, crc_next;
  logic [7:0]  crc_in;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  txd_q, txd_d;
  logic        tx_en_q, tx_en_d;
  logic        tx_er_q, tx_er_d;
  logic        underrun_q, underrun_d;

  // Handshake: a byte transfers on a rising edge where s_valid && s_ready; s_ready is a pure
  // function of the state register, and once s_valid is raised in DATA it must stay high
  // through s_last (a gap aborts the frame).
  assign s_ready    = (state_q == ST_SFD) || (state_q == ST_DATA) || (state_q == ST_DROP);
  assign tx_busy    = (state_q != ST_IDLE);
  assign gmii_txd   = txd_q;
  assign gmii_tx_en = tx_en_q;
  assign gmii_tx_er = tx_er_q;
  assign underrun   = underrun_q;
  assign frame_cnt  = frame_cnt_q;

  assign byte_inc = (&byte_cnt_q) ? byte_cnt_q : byte_cnt_q + 11'd1;
  assign crc_in   = (state_q == ST_PAD) ? 8'h00 : s_data;

  crc32_d8 u_crc (
    .crc_i  (crc_q),
    .data_i (crc_in),
    .crc_o  (crc_next)
  );

  always_ff @(posedge gmii_tx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (s_valid && tx_link_up) state_d = ST_PREAMBLE;
      ST_PREAMBLE: if (aux_cnt_q == PRE_LAST) state_d = ST_SFD;
      ST_SFD, ST_DATA: begin
        if (!s_valid)    state_d = ST_DROP;
        else if (s_last) state_d = (byte_inc < MIN_LEN) ? ST_PAD : ST_FCS;
        else             state_d = ST_DATA;
      end
      ST_PAD:      if (byte_inc >= MIN_LEN) state_d = ST_FCS;
      ST_FCS:      if (aux_cnt_q == 8'd3) state_d = ST_IFG;
      ST_IFG:      if (aux_cnt_q == IFG_LAST) state_d = ST_IDLE;
      ST_DROP:     if (s_valid && s_last) state_d = ST_IFG;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Counters and CRC; the IFG state lasts one extra cycle because the last FCS byte is
  // still on the registered outputs during its first cycle.
  always_comb begin
    aux_cnt_d   = (state_d != state_q) ? 8'd0 : aux_cnt_q + 8'd1;
    byte_cnt_d  = byte_cnt_q;
    crc_d       = crc_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ST_IDLE: begin
        byte_cnt_d = 11'd0;
        crc_d      = CRC32_INIT;
      end
      ST_SFD, ST_DATA, ST_PAD: begin
        if (s_valid || (state_q == ST_PAD)) begin
          crc_d      = crc_next;
          byte_cnt_d = byte_inc;
        end
      end
      ST_FCS:  if (state_d == ST_IFG) frame_cnt_d = frame_cnt_q + 16'd1;
      default: ;
    endcase
  end

  always_comb begin
    txd_d      = 8'h00;
    tx_en_d    = 1'b0;
    tx_er_d    = 1'b0;
    underrun_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s_valid && tx_link_up) begin
          txd_d   = ETH_PREAMBLE;
          tx_en_d = 1'b1;
        end
      end
      ST_PREAMBLE: begin
        tx_en_d = 1'b1;
        txd_d   = (aux_cnt_q == PRE_LAST) ? ETH_SFD : ETH_PREAMBLE;
      end
      ST_SFD, ST_DATA: begin
        tx_en_d = 1'b1;
        if (s_valid) begin
          txd_d = s_data;
        end else begin
          tx_er_d    = 1'b1;
          underrun_d = 1'b1;
        end
      end
      ST_PAD: tx_en_d = 1'b1;
      ST_FCS: begin
        tx_en_d = 1'b1;
        txd_d   = fcs_byte(crc_q, aux_cnt_q[1:0]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge gmii_tx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      byte_cnt_q  <= 11'd0;
      aux_cnt_q   <= 8'd0;
      crc_q       <= CRC32_INIT;
      frame_cnt_q <= 16'd0;
      txd_q       <= 8'h00;
      tx_en_q     <= 1'b0;
      tx_er_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      byte_cnt_q  <= byte_cnt_d;
      aux_cnt_q   <= aux_cnt_d;
      crc_q       <= crc_d;
      frame_cnt_q <= frame_cnt_d;
      txd_q       <= txd_d;
      tx_en_q     <= tx_en_d;
      tx_er_q     <= tx_er_d;
      underrun_q  <= underrun_d;
    end
  end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Scoreboard bench for gmii_tx_framer: default instance plus a MIN_FRAME=0 instance.
module tb_gmii_tx_framer;

  localparam int MINF = 60;
  localparam int BOUND = 3000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #4 clk = ~clk;

  logic a_link, a_valid, a_last, a_ready, a_en, a_er, a_busy, a_under;
  logic [7:0] a_data, a_txd;
  logic [15:0] a_fcnt;
  logic b_link, b_valid, b_last, b_ready, b_en, b_er, b_busy, b_under;
  logic [7:0] b_data, b_txd;
  logic [15:0] b_fcnt;

  gmii_tx_framer dut_a (
    .gmii_tx_clk(clk), .sys_rst_n(rst_n), .tx_link_up(a_link),
    .s_data(a_data), .s_valid(a_valid), .s_last(a_last), .s_ready(a_ready),
    .gmii_txd(a_txd), .gmii_tx_en(a_en), .gmii_tx_er(a_er),
    .tx_busy(a_busy), .underrun(a_under), .frame_cnt(a_fcnt)
  );

  gmii_tx_framer #(.MIN_FRAME(0)) dut_b (
    .gmii_tx_clk(clk), .sys_rst_n(rst_n), .tx_link_up(b_link),
    .s_data(b_data), .s_valid(b_valid), .s_last(b_last), .s_ready(b_ready),
    .gmii_txd(b_txd), .gmii_tx_en(b_en), .gmii_tx_er(b_er),
    .tx_busy(b_busy), .underrun(b_under), .frame_cnt(b_fcnt)
  );

  int n_checks = 0;
  int n_err = 0;
  // entries are {underrun, gmii_tx_er, gmii_txd} for each gmii_tx_en-high cycle
  logic [9:0] exp_q[$];
  logic [9:0] exp_b_q[$];
  logic [7:0] pay[$];

  int a_hi = 0, a_lo = 0, a_ifg = 0, a_last_hi = 0, a_last_gap = 0;
  logic a_prev = 1'b0;
  int b_hi = 0, b_last_hi = 0;
  logic b_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: bound of %0d cycles expired, expected completion", name, BOUND);
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 8; b++) begin
      if ((r[0] ^ d[b]) == 1'b1) r = (r >> 1) ^ 32'hEDB88320;
      else                       r = r >> 1;
    end
    return r;
  endfunction

  // Expected GMII stream for the default instance; drop_after >= 0 models an aborted frame.
  task automatic push_frame(input int drop_after);
    logic [31:0] c;
    logic [7:0] b;
    int total;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 7; i++) exp_q.push_back({2'b00, 8'h55});
    exp_q.push_back({2'b00, 8'hD5});
    if (drop_after >= 0) begin
      for (int i = 0; i < drop_after; i++) exp_q.push_back({2'b00, pay[i]});
      exp_q.push_back({2'b11, 8'h00});
    end else begin
      total = (pay.size() < MINF) ? MINF : pay.size();
      for (int i = 0; i < total; i++) begin
        b = (i < pay.size()) ? pay[i] : 8'h00;
        c = crc_step(c, b);
        exp_q.push_back({2'b00, b});
      end
      c = ~c;
      for (int k = 0; k < 4; k++) exp_q.push_back({2'b00, c[8*k +: 8]});
    end
  endtask

  task automatic send(input bit sel, input int drop_after, input bit keep);
    int i;
    int guard;
    bit rdy;
    bit dropped;
    i = 0; guard = 0; dropped = 1'b0;
    while (i < pay.size() && guard < BOUND) begin
      @(negedge clk);
      guard++;
      if (i == drop_after && !dropped) begin
        if (sel) b_valid = 1'b0; else a_valid = 1'b0;
        dropped = 1'b1;
        rdy = 1'b0;
      end else begin
        if (sel) begin
          b_valid = 1'b1; b_data = pay[i]; b_last = (i == pay.size() - 1);
          rdy = b_ready;
        end else begin
          a_valid = 1'b1; a_data = pay[i]; a_last = (i == pay.size() - 1);
          rdy = a_ready;
        end
      end
      @(posedge clk);
      if (rdy) i++;
    end
    if (guard >= BOUND) fail_bound("send");
    if (!keep) begin
      @(negedge clk);
      if (sel) begin b_valid = 1'b0; b_last = 1'b0; end
      else     begin a_valid = 1'b0; a_last = 1'b0; end
    end
  endtask

  task automatic wait_done(input bit sel);
    int g;
    g = 0;
    while (g < BOUND && ((sel ? b_busy : a_busy) ||
           (sel ? exp_b_q.size() : exp_q.size()) != 0)) begin
      @(negedge clk);
      g++;
    end
    if (g >= BOUND) fail_bound("wait_done");
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (a_en) begin
        if (!a_prev) begin a_last_gap = a_lo; a_hi = 0; end
        a_hi++;
        if (exp_q.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL gmii_a: got 0x%0h, expected no transmission", {a_under, a_er, a_txd});
        end else begin
          check("gmii_a", {22'd0, a_under, a_er, a_txd}, {22'd0, exp_q.pop_front()});
        end
      end else begin
        if (a_prev) begin a_last_hi = a_hi; a_lo = 0; a_ifg = 0; end
        a_lo++;
        if (a_busy) a_ifg++;
        if (a_er || a_under) begin
          n_checks++; n_err++;
          $display("FAIL idle_err_a: got er=%0b underrun=%0b, expected 0 while tx_en low", a_er, a_under);
        end
      end
      a_prev = a_en;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (b_en) begin
        if (!b_prev) b_hi = 0;
        b_hi++;
        if (exp_b_q.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL gmii_b: got 0x%0h, expected no transmission", {b_under, b_er, b_txd});
        end else begin
          check("gmii_b", {22'd0, b_under, b_er, b_txd}, {22'd0, exp_b_q.pop_front()});
        end
      end else if (b_prev) begin
        b_last_hi = b_hi;
      end
      b_prev = b_en;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_txd"},    {24'd0, a_txd}, 32'd0);
    check({tag, "_en"},     {31'd0, a_en}, 32'd0);
    check({tag, "_er"},     {31'd0, a_er}, 32'd0);
    check({tag, "_ready"},  {31'd0, a_ready}, 32'd0);
    check({tag, "_busy"},   {31'd0, a_busy}, 32'd0);
    check({tag, "_under"},  {31'd0, a_under}, 32'd0);
    check({tag, "_fcnt"},   {16'd0, a_fcnt}, 32'd0);
  endtask

  initial begin
    int g;
    a_link = 1'b1; a_valid = 1'b0; a_last = 1'b0; a_data = 8'h00;
    b_link = 1'b0; b_valid = 1'b0; b_last = 1'b0; b_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 64-byte payload 0x00..0x3F
    pay.delete();
    for (int i = 0; i < 64; i++) pay.push_back(8'(i));
    push_frame(-1);
    send(1'b0, -1, 1'b0);
    wait_done(1'b0);
    check("len64_en_high", a_last_hi, 76);
    check("len64_ifg_low", a_ifg, 12);
    check("len64_fcnt", {16'd0, a_fcnt}, 1);

    // 1-byte payload padded to 60
    pay.delete();
    pay.push_back(8'hAA);
    push_frame(-1);
    send(1'b0, -1, 1'b0);
    wait_done(1'b0);
    check("pad_en_high", a_last_hi, 72);
    check("pad_fcnt", {16'd0, a_fcnt}, 2);

    // underrun after 10 of 20 payload bytes
    pay.delete();
    for (int i = 0; i < 20; i++) pay.push_back(8'(3 * i + 1));
    push_frame(10);
    send(1'b0, 10, 1'b0);
    wait_done(1'b0);
    check("underrun_en_high", a_last_hi, 19);
    check("underrun_fcnt", {16'd0, a_fcnt}, 2);

    // back-to-back frames with s_valid held high
    pay.delete();
    for (int i = 1; i <= 5; i++) pay.push_back(8'(i));
    push_frame(-1);
    send(1'b0, -1, 1'b1);
    pay.delete();
    for (int i = 0; i < 3; i++) pay.push_back(8'(8'hA0 + i));
    push_frame(-1);
    send(1'b0, -1, 1'b0);
    wait_done(1'b0);
    check("b2b_gap", a_last_gap, 13);
    check("b2b_en_high", a_last_hi, 72);
    check("b2b_fcnt", {16'd0, a_fcnt}, 4);

    // link down in IDLE: nothing starts
    @(negedge clk);
    a_link = 1'b0; a_valid = 1'b1; a_data = 8'h77; a_last = 1'b0;
    repeat (30) @(negedge clk);
    check("linkdown_busy", {31'd0, a_busy}, 0);
    check("linkdown_ready", {31'd0, a_ready}, 0);
    check("linkdown_fcnt", {16'd0, a_fcnt}, 4);
    a_valid = 1'b0;
    @(negedge clk);
    a_link = 1'b1;
    @(negedge clk);

    // reset asserted during DATA after three payload bytes are on GMII
    for (int i = 0; i < 7; i++) exp_q.push_back({2'b00, 8'h55});
    exp_q.push_back({2'b00, 8'hD5});
    for (int i = 0; i < 3; i++) exp_q.push_back({2'b00, 8'h11});
    a_data = 8'h11; a_last = 1'b0; a_valid = 1'b1;
    g = 0;
    while (g < BOUND && exp_q.size() != 0) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (g >= BOUND) fail_bound("reset_mid_frame");
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    a_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // clean frame after reset
    pay.delete();
    pay.push_back(8'hDE);
    pay.push_back(8'hAD);
    push_frame(-1);
    send(1'b0, -1, 1'b0);
    wait_done(1'b0);
    check("postreset_en_high", a_last_hi, 72);
    check("postreset_fcnt", {16'd0, a_fcnt}, 1);

    // MIN_FRAME=0 instance, payload "123456789"
    b_link = 1'b1;
    pay.delete();
    for (int i = 0; i < 9; i++) pay.push_back(8'(8'h31 + i));
    for (int i = 0; i < 7; i++) exp_b_q.push_back({2'b00, 8'h55});
    exp_b_q.push_back({2'b00, 8'hD5});
    for (int i = 0; i < 9; i++) exp_b_q.push_back({2'b00, pay[i]});
    exp_b_q.push_back(10'h026);
    exp_b_q.push_back(10'h039);
    exp_b_q.push_back(10'h0F4);
    exp_b_q.push_back(10'h0CB);
    send(1'b1, -1, 1'b0);
    wait_done(1'b1);
    check("nopad_en_high", b_last_hi, 21);
    check("nopad_fcnt", {16'd0, b_fcnt}, 1);

    check("scoreboard_a_empty", exp_q.size(), 0);
    check("scoreboard_b_empty", exp_b_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
